csa_accumulator: RTL
====================

CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning accumulator and operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, meaning bits resolved per cycle during final carry-propagate; WIDTH a multiple of CHUNK, N = WIDTH/CHUNK.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning an operand is offered.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts an operand this cycle.
REQ-007 SHALL have port in_data, input, WIDTH, meaning the unsigned operand.
REQ-008 SHALL have port in_last, input, 1, meaning the operand is the final one of the current sum.
REQ-009 SHALL have port out_valid, output, 1, meaning a resolved sum is presented.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer takes the sum.
REQ-011 SHALL have port out_data, output, WIDTH, meaning the resolved sum modulo 2^WIDTH.

Function
REQ-012 SHALL hold the running total in redundant form as sum register S and carry register C (WIDTH bits each, weight-aligned), with value S+C mod 2^WIDTH.
REQ-013 SHALL implement the FSM states ACCUM, RESOLVE and OUTPUT; reset state is ACCUM.
REQ-014 SHALL drive in_ready high only in ACCUM; an input handshake is in_valid && in_ready.
REQ-015 SHALL, on each input handshake, update S <= S^C^in_data and C <= majority(S,C,in_data) shifted left 1, with the top bit discarded (one 3:2 compression per cycle, no carry propagation).
REQ-016 SHALL move ACCUM->RESOLVE on an input handshake with in_last=1; that operand is included in the sum.
REQ-017 SHALL spend exactly N cycles in RESOLVE; cycle k (k=0..N-1) adds bits [k*CHUNK +: CHUNK] of S and C plus a 1-bit inter-chunk carry into the same bits of the result register; the carry out of chunk N-1 is discarded.
REQ-018 SHALL move RESOLVE->OUTPUT after the Nth resolve cycle; out_valid is first high after the Nth rising edge following the last-beat handshake edge.
REQ-019 SHALL hold out_valid high and out_data stable in OUTPUT until out_ready=1.
REQ-020 SHALL, on an output handshake, clear S, C and the inter-chunk carry and return to ACCUM; in_ready is high in the following cycle (no same-cycle input acceptance).
REQ-021 SHALL ignore in_valid, in_data and in_last outside ACCUM.
REQ-022 SHALL wrap sums modulo 2^WIDTH with no overflow indication.
REQ-023 SHALL treat a single beat with in_last=1 from a cleared state as a valid one-operand sum equal to in_data.

Reset
REQ-024 SHALL, when rst=1 at a rising edge, set state=ACCUM, S=0, C=0, result=0, inter-chunk carry=0 and chunk index=0, from any state including mid-RESOLVE or OUTPUT.
REQ-025 SHALL drive out_valid=0 and out_data=0 and in_ready=1 in the cycle after reset.
REQ-026 SHALL discard any partial sum and never emit it after a reset.

Configuration
REQ-027 SHALL, when macro CSA_ACCUMULATOR_COUNT_EN is defined, add output out_count (16 bits) giving the number of operands in the presented sum, saturating at 65535, reset to 0, cleared on output handshake, valid while out_valid=1.
REQ-028 SHALL, when CSA_ACCUMULATOR_COUNT_EN is undefined, omit out_count and its counter entirely, with all other behaviour identical.

Verification (WIDTH=8, CHUNK=4, N=2)
REQ-029 SHALL pass: beats 12, 33, 1(last), out_ready=1 -> out_valid high 2 edges after last beat, out_data=46.
REQ-030 SHALL pass: beats 200, 100(last) -> out_data=44 (wrap mod 256).
REQ-031 SHALL pass: single beat 7 with in_last=1 -> out_data=7; in_ready low during RESOLVE/OUTPUT, in_valid pulses there ignored.
REQ-032 SHALL pass: out_ready held 0 for 5 cycles after out_valid -> out_valid and out_data=24 (beats 1, 23(last)) stable throughout; in_ready high exactly 1 cycle after handshake.
REQ-033 SHALL pass: rst asserted during first RESOLVE cycle of beats 255, 255(last) -> no out_valid; next beat 5(last) yields out_data=5.
REQ-034 SHALL pass with CSA_ACCUMULATOR_COUNT_EN: beats 12, 33, 1(last) -> out_count=3; the next sum of one beat -> out_count=1.

Source files
------------

// File: rtl/csa_accumulator.sv
// Carry-save accumulator: one 3:2 compression per operand, chunked carry-propagate on in_last.
// Latency: sum presented WIDTH/CHUNK cycles after the last-beat handshake.
// Backpressure: in_ready only in ACCUM; result held until out_ready. Optional out_count via CSA_ACCUMULATOR_COUNT_EN.
module csa_accumulator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef CSA_ACCUMULATOR_COUNT_EN
    output logic [15:0]      out_count,
`endif
    output logic [WIDTH-1:0] out_data
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t          state_q, state_nxt;
    logic [WIDTH-1:0] s_q, c_q, result_q;
    logic             cy_q;
    logic [IW-1:0]    idx_q;

    logic             in_hs, out_hs;
    logic [WIDTH-1:0] maj;
    logic [CHUNK-1:0] s_chunk, c_chunk;
    logic [CHUNK:0]   csum;
    int               base;

    always_comb begin
        state_nxt = state_q;
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == OUTPUT);
        in_hs     = in_valid && in_ready;
        out_hs    = out_valid && out_ready;
        case (state_q)
            ACCUM:   if (in_hs && in_last)   state_nxt = RESOLVE;
            RESOLVE: if (idx_q == LAST_IDX)  state_nxt = OUTPUT;
            OUTPUT:  if (out_ready)          state_nxt = ACCUM;
            default:                         state_nxt = ACCUM;
        endcase
    end

    always_comb begin
        maj     = (s_q & c_q) | (s_q & in_data) | (c_q & in_data);
        base    = int'(idx_q) * CHUNK;
        s_chunk = s_q[base +: CHUNK];
        c_chunk = c_q[base +: CHUNK];
        csum    = {1'b0, s_chunk} + {1'b0, c_chunk} + (CHUNK + 1)'(cy_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ACCUM;
            s_q      <= '0;
            c_q      <= '0;
            result_q <= '0;
            cy_q     <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q <= state_nxt;
            case (state_q)
                ACCUM: begin
                    if (in_hs) begin
                        s_q <= s_q ^ c_q ^ in_data;
                        // carry out of the top bit is outside the modulus
                        c_q <= {maj[WIDTH-2:0], 1'b0};
                    end
                end
                RESOLVE: begin
                    result_q[base +: CHUNK] <= csum[CHUNK-1:0];
                    cy_q                    <= csum[CHUNK];
                    idx_q                   <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                end
                OUTPUT: begin
                    if (out_ready) begin
                        s_q   <= '0;
                        c_q   <= '0;
                        cy_q  <= 1'b0;
                        idx_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data = result_q;

`ifdef CSA_ACCUMULATOR_COUNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (out_hs) begin
            cnt_q <= '0;
        end else if (in_hs && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign out_count = cnt_q;
`endif

endmodule
